// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss/fill controller.
// Parameter defaults and derived field widths used by every fill instance.
package cache_pkg;

  localparam int DEF_ADDR_WIDTH      = 16;
  localparam int DEF_DATA_WIDTH      = 16;
  localparam int DEF_WORDS_PER_BLOCK = 8;
  localparam int DEF_BYTES_PER_WORD  = 2;

  localparam int BLOCK_OFFSET_BITS = $clog2(DEF_WORDS_PER_BLOCK * DEF_BYTES_PER_WORD);
  localparam int WORD_SEL_BITS     = $clog2(DEF_WORDS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FILL = 2'd2
  } fill_state_e;

  // Clears the byte-offset-within-block bits of an address.
  function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                             input int unsigned offset_bits);
    return (addr >> offset_bits) << offset_bits;
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for a block fill: synchronous reset, clear, and enable,
// saturating at MAX_COUNT so it holds once every word is accounted for.
module fill_counter #(
  parameter int MAX_COUNT = 8,
  parameter int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != CNT_W'(MAX_COUNT))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: waits for main memory, fetches one block as a burst of
// word reads, streams returned words to the data array and writes the tag once.
//
// state | meaning
// IDLE  | nothing in flight
// WAIT  | miss accepted, other cache owns main memory
// FILL  | requests issuing and/or words returning
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter int BYTES_PER_WORD  = DEF_BYTES_PER_WORD,
  localparam int SEL_BITS       = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_busy,
  input  logic                  memory_data_valid,
  input  logic [DATA_WIDTH-1:0] memory_data,
  output logic                  fsm_busy,
  output logic                  mem_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [SEL_BITS-1:0]   data_word_sel,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  write_tag_array
);

  localparam int OFFSET_BITS = $clog2(WORDS_PER_BLOCK * BYTES_PER_WORD);
  localparam int CNT_BITS    = $clog2(WORDS_PER_BLOCK + 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(WORDS_PER_BLOCK);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WORDS_PER_BLOCK - 1);

  fill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_BITS-1:0]   issue_cnt, recv_cnt;
  logic                  issue_en, recv_en, cnt_clr;

  fill_counter #(.MAX_COUNT(WORDS_PER_BLOCK), .CNT_W(CNT_BITS)) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (issue_en),
    .count (issue_cnt)
  );

  fill_counter #(.MAX_COUNT(WORDS_PER_BLOCK), .CNT_W(CNT_BITS)) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (recv_en),
    .count (recv_cnt)
  );

  // Base is captured only on acceptance, so a changing miss_address in WAIT is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && miss_detected) begin
        base_q <= ADDR_WIDTH'(align_addr(32'(miss_address), OFFSET_BITS));
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    fsm_busy         = (state_q != IDLE) || miss_detected;
    mem_enable       = 1'b0;
    memory_address   = base_q;
    write_data_array = 1'b0;
    data_word_sel    = recv_cnt[SEL_BITS-1:0];
    fill_data        = '0;
    write_tag_array  = 1'b0;
    issue_en         = 1'b0;
    recv_en          = 1'b0;
    cnt_clr          = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d = memory_busy ? WAIT : FILL;
        end
      end
      WAIT: begin
        if (!memory_busy) begin
          state_d = FILL;
        end
      end
      FILL: begin
        issue_en       = 1'b1;
        mem_enable     = (issue_cnt < CNT_FULL);
        memory_address = base_q + ADDR_WIDTH'(issue_cnt) * ADDR_WIDTH'(BYTES_PER_WORD);
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_data        = memory_data;
          recv_en          = 1'b1;
          // Completion is driven by returned words, independent of memory latency.
          if (recv_cnt == CNT_LAST) begin
            write_tag_array = 1'b1;
            cnt_clr         = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller placed between one cache (I or D) and the shared 4-cycle pipelined main memory.
- On a cache miss it waits for the memory to be free, then fetches the whole 16-byte block as 8 consecutive word reads.
- It streams each returned word into the cache data array, then writes the tag array once when the block is complete.
- One instance per cache; the top-level memory wrapper arbitrates between instances through memory_busy.

Parameters:
ADDR_WIDTH, 16, byte address width
DATA_WIDTH, 16, memory word width
WORDS_PER_BLOCK, 8, words fetched per fill (power of 2)
BYTES_PER_WORD, 2, address increment per word

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
miss_detected  input  1  cache lookup missed this cycle
miss_address  input  ADDR_WIDTH  byte address that missed
memory_busy  input  1  other cache owns main memory this cycle
memory_data_valid  input  1  main memory returning a word this cycle
memory_data  input  DATA_WIDTH  returned word
fsm_busy  output  1  stall to pipeline; fill pending or in progress
mem_enable  output  1  issue read request to main memory
memory_address  output  ADDR_WIDTH  address of current read request
write_data_array  output  1  write fill_data into cache data array
data_word_sel  output  log2(WORDS_PER_BLOCK)  word offset within block being written
fill_data  output  DATA_WIDTH  word to write (memory_data passthrough)
write_tag_array  output  1  one-cycle pulse: block complete, write tag/valid

Behaviour:
- Reset: state IDLE; issue and receive counters = 0; latched base = 0; all outputs 0; memory_address = 0.
- Reset mid-fill: same as reset. Counters are cleared, no tag write occurs, and the partial block stays invalid.
- States:
  - IDLE: nothing in flight.
  - WAIT: miss seen while memory_busy.
  - FILL: requests issuing and/or words returning.
- IDLE transitions:
  - miss_detected & ~memory_busy -> FILL.
  - miss_detected & memory_busy -> WAIT.
  - In both cases latch base = miss_address with low log2(WORDS_PER_BLOCK*BYTES_PER_WORD) bits cleared (0x1236 -> 0x1230).
- WAIT: stays while memory_busy; ~memory_busy -> FILL. miss_address is not re-sampled.
- fsm_busy is combinational: (state != IDLE) | miss_detected. It asserts in the same cycle as the miss.
- FILL issue:
  - mem_enable = 1 while issue count < WORDS_PER_BLOCK.
  - memory_address = base + issue count * BYTES_PER_WORD, truncated to ADDR_WIDTH.
  - Issue count increments every FILL cycle until it reaches 8, then holds.
  - mem_enable = 0 and memory_address = base in IDLE/WAIT.
- FILL receive:
  - write_data_array = memory_data_valid in FILL.
  - data_word_sel = receive count; fill_data = memory_data.
  - Receive count increments on each valid word.
- Completion: the valid word with receive count = 7 also asserts write_tag_array in the same cycle, then -> IDLE with counters cleared. fsm_busy drops the following cycle.
- Latency: the FSM counts valid pulses, not cycles, so it works for any memory latency.
  - With a 4-cycle memory, the fill lasts 8 issue cycles + 3, i.e. 11 FILL cycles.
  - Total = 12 cycles from the miss to fsm_busy low when the memory is free.
- memory_busy or miss_detected changing during FILL is ignored; a granted fill always completes.
- memory_data_valid in IDLE/WAIT is ignored; no writes are issued.
- A miss presented in the cycle write_tag_array pulses is not accepted; it is re-evaluated from IDLE on the next cycle.

Decomposition:
- Shared package cache_pkg:
  - state enum {IDLE, WAIT, FILL}.
  - BLOCK_OFFSET_BITS, WORD_SEL_BITS.
  - Address-align function.
- One sub-module, fill_counter: synchronous-reset, enable and clear, saturating at WORDS_PER_BLOCK.
  - Instantiated twice: issue count and receive count.

Test Plan:
- Miss 0x1236, memory free, 4-cycle memory model:
  - Addresses 0x1230, 0x1232 … 0x123E are requested on consecutive cycles.
  - write_data_array fires 8 times with data_word_sel 0..7.
  - write_tag_array pulses exactly once, concurrent with word 7.
  - fsm_busy is high for 12 cycles.
- Miss 0x00F2 with memory_busy high for 5 cycles: WAIT holds with mem_enable = 0, then the fill starts at 0x00F0. Toggling miss_address during WAIT does not change the base.
- Miss 0xFFFE: addresses 0xFFF0..0xFFFE, with no overflow into 0x0000.
- rst asserted after the 3rd returned word:
  - All outputs are 0 next cycle and there is no write_tag_array.
  - A new miss 0x4000 then completes a clean full fill.
- Stray memory_data_valid in IDLE, and memory_busy asserted mid-FILL: neither changes the state. No data writes in IDLE; the fill completes normally.
- Back-to-back misses 0x2000 then 0x3008, second asserted during the tag pulse: the second fill starts one cycle later with base 0x3000.
